// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode constants and the control-bit bundle
// produced by the opcode table, used by the decode stage and its bench.
package decode_pkg;

    localparam int unsigned OP_LDD    = 32'd1;
    localparam int unsigned OP_STD    = 32'd2;
    localparam int unsigned OP_LDM    = 32'd3;
    localparam int unsigned OP_ALU_LO = 32'd8;
    localparam int unsigned OP_ALU_HI = 32'd15;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic wb;
        logic imm_sel;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    // Pure opcode-to-control table; unlisted opcodes decode to no side effects.
    function automatic ctrl_t decode_ctrl(input int unsigned opc);
        ctrl_t c;
        c = CTRL_NONE;
        if (opc == OP_LDD) begin
            c.mem_read = 1'b1;
            c.wb       = 1'b1;
        end else if (opc == OP_STD) begin
            c.mem_write = 1'b1;
        end else if (opc == OP_LDM) begin
            c.wb      = 1'b1;
            c.imm_sel = 1'b1;
        end else if (opc >= OP_ALU_LO && opc <= OP_ALU_HI) begin
            c.wb = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/reg_file_p.sv
// Register file: two combinational read ports, one synchronous write port,
// with write-through so a same-cycle write is visible on the read ports.
module reg_file_p #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    localparam int AW    = $clog2(NREG)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wen,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr1,
    input  logic [AW-1:0]     i_raddr2,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [DATA_W-1:0] o_rdata2
);

    logic [DATA_W-1:0] r_regs [NREG];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_wen) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = (i_wen && (i_waddr == i_raddr1)) ? i_wdata : r_regs[i_raddr1];
    assign o_rdata2 = (i_wen && (i_waddr == i_raddr2)) ? i_wdata : r_regs[i_raddr2];

endmodule

// File: rtl/param_decode_stage.sv
// Instruction decode stage: field split, register read with bypass, opcode
// control decode, load-use stall and a single ID/EX register with hold/flush.
module param_decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int NREG       = 8,
    parameter int OPC_W      = 5,
    parameter int IMM_SIGNED = 0,
    localparam int AW        = $clog2(NREG),
    localparam int IW        = OPC_W + 2*AW + 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IW-1:0]     instruction,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              out_valid,
    output logic [OPC_W-1:0]  out_opcode,
    output logic [AW-1:0]     out_rd,
    output logic [DATA_W-1:0] out_rs1_data,
    output logic [DATA_W-1:0] out_rs2_data,
    output logic [DATA_W-1:0] out_imm,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_wb,
    output logic              out_imm_sel
);

    function automatic logic [DATA_W-1:0] ext_imm(input logic [7:0] imm);
        logic signed [7:0] imm_s;
        imm_s = signed'(imm);
        if (IMM_SIGNED != 0) begin
            return DATA_W'(imm_s);
        end
        return DATA_W'(imm);
    endfunction

    logic [OPC_W-1:0]  w_opcode_p0;
    logic [AW-1:0]     w_rs1_p0;
    logic [AW-1:0]     w_rs2_p0;
    logic [7:0]        w_imm_p0;
    logic [DATA_W-1:0] w_rs1_data_p0;
    logic [DATA_W-1:0] w_rs2_data_p0;
    ctrl_t             w_ctrl_p0;
    logic              w_hazard_p0;
    logic              w_advance_p0;
    logic              w_load_p0;

    logic              r_vld_p1;
    ctrl_t             r_ctrl_p1;
    logic [OPC_W-1:0]  r_opcode_p1;
    logic [AW-1:0]     r_rd_p1;
    logic [DATA_W-1:0] r_rs1_data_p1;
    logic [DATA_W-1:0] r_rs2_data_p1;
    logic [DATA_W-1:0] r_imm_p1;

    // ---- p0: field split, register read, control decode, hazard ----
    assign w_opcode_p0 = instruction[IW-1 -: OPC_W];
    assign w_rs1_p0    = instruction[IW-OPC_W-1 -: AW];
    assign w_rs2_p0    = instruction[IW-OPC_W-AW-1 -: AW];
    assign w_imm_p0    = instruction[7:0];
    assign w_ctrl_p0   = decode_ctrl(32'(w_opcode_p0));

    reg_file_p #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_reg_file (
        .i_clk    (clk),
        .i_rst_n  (reset),
        .i_wen    (wb_en),
        .i_waddr  (wb_addr),
        .i_wdata  (wb_data),
        .i_raddr1 (w_rs1_p0),
        .i_raddr2 (w_rs2_p0),
        .o_rdata1 (w_rs1_data_p0),
        .o_rdata2 (w_rs2_data_p0)
    );

    // A load in ID/EX cannot forward its result yet, so any consumer must wait one slot.
    assign w_hazard_p0  = r_vld_p1 & r_ctrl_p1.mem_read &
                          ((r_rd_p1 == w_rs1_p0) | (r_rd_p1 == w_rs2_p0));
    assign w_advance_p0 = ~r_vld_p1 | ex_ready;
    assign in_ready     = w_advance_p0 & ~w_hazard_p0 & ~flush;
    assign w_load_p0    = in_valid & in_ready;

    // ---- p1: ID/EX register ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld_p1      <= 1'b0;
            r_ctrl_p1     <= CTRL_NONE;
            r_opcode_p1   <= '0;
            r_rd_p1       <= '0;
            r_rs1_data_p1 <= '0;
            r_rs2_data_p1 <= '0;
            r_imm_p1      <= '0;
        end else if (flush) begin
            r_vld_p1  <= 1'b0;
            r_ctrl_p1 <= CTRL_NONE;
        end else if (w_load_p0) begin
            r_vld_p1      <= 1'b1;
            r_ctrl_p1     <= w_ctrl_p0;
            r_opcode_p1   <= w_opcode_p0;
            r_rd_p1       <= w_rs1_p0;
            r_rs1_data_p1 <= w_rs1_data_p0;
            r_rs2_data_p1 <= w_rs2_data_p0;
            r_imm_p1      <= ext_imm(w_imm_p0);
        end else if (w_advance_p0) begin
            r_vld_p1  <= 1'b0;
            r_ctrl_p1 <= CTRL_NONE;
        end
    end

    assign out_valid     = r_vld_p1;
    assign out_opcode    = r_opcode_p1;
    assign out_rd        = r_rd_p1;
    assign out_rs1_data  = r_rs1_data_p1;
    assign out_rs2_data  = r_rs2_data_p1;
    assign out_imm       = r_imm_p1;
    assign out_mem_read  = r_ctrl_p1.mem_read;
    assign out_mem_write = r_ctrl_p1.mem_write;
    assign out_wb        = r_ctrl_p1.wb;
    assign out_imm_sel   = r_ctrl_p1.imm_sel;

endmodule

// File: doc/param_decode_stage.md
PARAM_DECODE_STAGE -- requirements
Module: param_decode_stage

Interface
REQ-001 Parameter DATA_W, 16, register and operand width in bits.
REQ-002 Parameter NREG, 8, number of architectural registers (power of two, >=2); AW = clog2(NREG).
REQ-003 Parameter OPC_W, 5, opcode field width; instruction width IW = OPC_W + 2*AW + 8.
REQ-004 Parameter IMM_SIGNED, 0, 1 = sign-extend the 8-bit immediate to DATA_W, 0 = zero-extend.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 in_valid / in_ready  in / out  1 / 1  fetch-side handshake; an instruction transfers when both are 1.
REQ-008 instruction  in  IW  fields: opcode [IW-1 -: OPC_W], rs1 next AW bits, rs2 next AW bits, imm [7:0]; rd = rs1.
REQ-009 wb_en, wb_addr, wb_data  in  1, AW, DATA_W  register-file write port from writeback.
REQ-010 flush  in  1  squash the held instruction (taken jump).
REQ-011 ex_ready  in  1  execute stage accepts the output when 1.
REQ-012 out_valid  out  1  ID/EX register holds a live instruction.
REQ-013 out_opcode, out_rd, out_rs1_data, out_rs2_data, out_imm  out  OPC_W, AW, DATA_W, DATA_W, DATA_W  registered decoded fields.
REQ-014 out_mem_read, out_mem_write, out_wb, out_imm_sel  out  1 each  registered control bits from the opcode table.

Function
REQ-015 The control bits shall be a pure function of opcode via the package table: OP_LDD -> mem_read, wb; OP_STD -> mem_write; OP_LDM -> wb, imm_sel; OP_ALU range -> wb; all other opcodes -> all zero.
REQ-016 The stage shall hold one instruction in an ID/EX register; latency from accepted instruction to out_valid is exactly 1 cycle.
REQ-017 Register reads shall be combinational on rs1/rs2 and captured into the ID/EX register.
REQ-018 Write-through bypass: if wb_en and wb_addr equals a read address in the same cycle, the read shall return wb_data.
REQ-019 Register file writes shall occur at the rising edge when wb_en = 1; no register is hardwired to zero.
REQ-020 Load-use hazard: when out_valid & out_mem_read and out_rd equals the incoming rs1 or rs2, in_ready shall be 0 for that cycle and a bubble (out_valid = 0) shall be loaded once the current output is consumed.
REQ-021 in_ready = (~out_valid | ex_ready) & ~hazard & ~flush.
REQ-022 When out_valid & ~ex_ready, all ID/EX outputs shall hold unchanged.
REQ-023 flush shall clear out_valid on the next edge regardless of ex_ready and block acceptance that cycle; flush has priority over accept and hold.
REQ-024 Register-file writes shall proceed during stall, hold and flush.
REQ-025 Immediate shall be extended to DATA_W per IMM_SIGNED; for DATA_W = 8 it passes unchanged.
REQ-026 When out_valid = 0 the data outputs are don't-care but the control outputs shall be 0.

Reset
REQ-027 On reset low: out_valid and all control outputs 0, data outputs 0, all registers of the file 0, taking effect immediately without a clock edge.
REQ-028 Reset mid-stall or mid-hold shall discard the held instruction; in_ready shall be 1 in the first cycle after reset deasserts.

Structure
REQ-029 Opcode constants (OP_LDD, OP_STD, OP_LDM, OP_ALU_LO/HI) and the control-bit struct shall live in shared package decode_pkg.
REQ-030 The register file shall be sub-module reg_file_p (parameters DATA_W, NREG; two read ports, one write port with bypass).
REQ-031 Hazard detection and control decode shall be inline logic in param_decode_stage.

Verification
REQ-032 Reset then write R3 = 0x1234, then decode ALU R3,R2 -> next cycle out_valid = 1, out_rs1_data = 0x1234, out_rd = 3.
REQ-033 Same-cycle wb_en to R5 = 0xBEEF and decode reading R5 -> out_rs1_data = 0xBEEF.
REQ-034 LDD R2 followed by ALU reading R2 -> in_ready = 0 for one cycle, one bubble (out_valid = 0), then the ALU instruction issues.
REQ-035 ex_ready = 0 for 3 cycles with out_valid = 1 -> outputs stable, in_ready = 0; ex_ready = 1 -> next instruction loads.
REQ-036 flush together with ex_ready = 0 -> out_valid = 0 next cycle; the instruction offered that cycle is not accepted.
REQ-037 IMM_SIGNED = 1, DATA_W = 16, imm 0x80 -> out_imm = 0xFF80; IMM_SIGNED = 0 -> 0x0080; reset asserted mid-hold -> out_valid = 0 immediately.
